// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic inter-stage pipeline latch (F/D, D/X, X/M, M/W) carrying a packed
//   DATA_W-bit payload through a valid/ready handshake with a 2-entry skid
//   buffer, synchronous flush and a saturating bubble counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. valid never depends on ready. Once valid is raised, the producer holds
//   it and the data stable until the transfer. in_ready is a registered signal
//   (= !skid valid), so there is no combinational path from out_ready to in_ready.
//
// Parameters
//   DATA_W        payload width
//   CNT_W         bubble_count width (saturates at all-ones)
// Ports
//   clock         rising-edge clock
//   ctrl_reset_n  synchronous reset, active-low
//   flush         discard both held entries this edge; same-edge accept dropped
//   in_valid      upstream payload valid
//   in_data       upstream payload
//   in_ready      stage can accept
//   out_valid     main entry valid
//   out_data      main entry payload
//   out_ready     downstream accepts (0 = stall)
//   occupancy     entries held (0..2)
//   bubble_count  edges with out_valid=0 since reset, saturating
//
// Build option
//   PIPE_ZERO_BUBBLE_EN  when defined, every entry left invalid by an edge also
//                        has its data cleared, so out_data == 0 whenever
//                        out_valid == 0 (bubbles decode as opcode 0 = nop).
//                        When undefined, invalid entries keep stale data.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;

  logic              m_valid_nxt, s_valid_nxt;
  logic [DATA_W-1:0] m_data_nxt, s_data_nxt;

  logic accept;
  logic drain;

  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  assign accept = in_valid & in_ready;
  assign drain  = m_valid & out_ready;

  always_comb begin
    m_valid_nxt = m_valid;
    s_valid_nxt = s_valid;
    m_data_nxt  = m_data;
    s_data_nxt  = s_data;

    if (flush) begin
      m_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
    end else if (!m_valid) begin
      // Skid is never occupied while main is empty.
      if (accept) begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = in_data;
      end
    end else if (drain) begin
      if (s_valid) begin
        // in_ready was low, so nothing can be accepted on this edge.
        m_data_nxt  = s_data;
        s_valid_nxt = 1'b0;
      end else if (accept) begin
        m_data_nxt  = in_data;
      end else begin
        m_valid_nxt = 1'b0;
      end
    end else if (!s_valid && accept) begin
      // Main stalled: overflow goes to skid, which drops in_ready next cycle.
      s_valid_nxt = 1'b1;
      s_data_nxt  = in_data;
    end

`ifdef PIPE_ZERO_BUBBLE_EN
    if (!m_valid_nxt) m_data_nxt = '0;
    if (!s_valid_nxt) s_data_nxt = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      m_valid      <= 1'b0;
      s_valid      <= 1'b0;
      m_data       <= '0;
      s_data       <= '0;
      bubble_count <= '0;
    end else begin
      m_valid <= m_valid_nxt;
      s_valid <= s_valid_nxt;
      m_data  <= m_data_nxt;
      s_data  <= s_data_nxt;
      if (!m_valid && (bubble_count != CNT_MAX))
        bubble_count <= bubble_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, stall/skid, flush with
// simultaneous accept, bubble counter saturation (CNT_W=4 instance) and reset
// during a full stall.
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic              clock;
  logic              ctrl_reset_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_count;

  // small-counter instance, idle input, own reset
  logic              sat_reset_n;
  logic              sat_in_ready;
  logic              sat_out_valid;
  logic [7:0]        sat_out_data;
  logic [1:0]        sat_occupancy;
  logic [3:0]        sat_bubble_count;
  logic              sat_flush;
  logic              sat_in_valid;
  logic [7:0]        sat_in_data;
  logic              sat_out_ready;

  int checks;
  int errors;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .bubble_count (bubble_count)
  );

  pipe_stage_skid #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clock        (clock),
    .ctrl_reset_n (sat_reset_n),
    .flush        (sat_flush),
    .in_valid     (sat_in_valid),
    .in_data      (sat_in_data),
    .in_ready     (sat_in_ready),
    .out_valid    (sat_out_valid),
    .out_data     (sat_out_data),
    .out_ready    (sat_out_ready),
    .occupancy    (sat_occupancy),
    .bubble_count (sat_bubble_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one active edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ctrl_reset_n = 1'b0;
    sat_reset_n  = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    sat_flush     = 1'b0;
    sat_in_valid  = 1'b0;
    sat_in_data   = '0;
    sat_out_ready = 1'b1;

    // 1 reset: two edges
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_occupancy", {62'd0, occupancy}, 64'd0);
    check("rst_bubble", {48'd0, bubble_count}, 64'd0);
    check("rst_sat_bubble", {60'd0, sat_bubble_count}, 64'd0);

    ctrl_reset_n = 1'b1;

    // 2 streaming 1..8, each appears one edge after accept
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i));
      exp_q.push_back(64'(i));
      tick();
      exp_v = exp_q.pop_front();
      check("stream_data", out_data, exp_v);
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, '0);
    tick();
    check("stream_end_valid", {63'd0, out_valid}, 64'd0);
    // only the first streaming edge saw an empty main
    check("stream_bubble", {48'd0, bubble_count}, 64'd1);

    // 3 stall / skid
    out_ready = 1'b0;
    drive(1'b1, 64'hA);
    tick();
    check("stall_a_occ", {62'd0, occupancy}, 64'd1);
    check("stall_a_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 64'hB);
    tick();
    check("stall_b_occ", {62'd0, occupancy}, 64'd2);
    check("stall_b_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 64'hC);
    tick();
    check("stall_c_occ", {62'd0, occupancy}, 64'd2);
    check("stall_hold_data", out_data, 64'hA);
    check("stall_c_in_ready", {63'd0, in_ready}, 64'd0);
    exp_q.push_back(64'hB);
    exp_q.push_back(64'hC);
    out_ready = 1'b1;
    tick();
    exp_v = exp_q.pop_front();
    check("release_b", out_data, exp_v);
    check("release_b_occ", {62'd0, occupancy}, 64'd1);
    check("release_b_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    exp_v = exp_q.pop_front();
    check("release_c", out_data, exp_v);
    check("release_c_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b0, '0);
    tick();
    check("release_empty_occ", {62'd0, occupancy}, 64'd0);
`ifdef PIPE_ZERO_BUBBLE_EN
    check("release_empty_data", out_data, 64'd0);
`else
    check("release_empty_data", out_data, 64'hC);
`endif
    check("stall_bubble", {48'd0, bubble_count}, 64'd2);

    // 4 flush with simultaneous accept
    out_ready = 1'b0;
    drive(1'b1, 64'h11);
    tick();
    drive(1'b1, 64'h22);
    tick();
    check("flush_pre_occ", {62'd0, occupancy}, 64'd2);
    flush = 1'b1;
    drive(1'b1, 64'hD);
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    check("flush_occ", {62'd0, occupancy}, 64'd0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_ZERO_BUBBLE_EN
    check("flush_data", out_data, 64'd0);
`else
    check("flush_data", out_data, 64'h11);
`endif
    out_ready = 1'b1;
    tick();
    check("flush_d_absent", {63'd0, out_valid}, 64'd0);
    check("flush_bubble", {48'd0, bubble_count}, 64'd4);

    // 5 saturation on the CNT_W=4 instance
    sat_reset_n = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", {60'd0, sat_bubble_count}, 64'd14);
    tick();
    check("sat_15", {60'd0, sat_bubble_count}, 64'd15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", {60'd0, sat_bubble_count}, 64'd15);

    // 6 reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, 64'h33);
    tick();
    drive(1'b1, 64'h44);
    tick();
    check("rst6_pre_occ", {62'd0, occupancy}, 64'd2);
    ctrl_reset_n = 1'b0;
    drive(1'b1, 64'h55);
    tick();
    check("rst6_valid", {63'd0, out_valid}, 64'd0);
    check("rst6_data", out_data, 64'd0);
    check("rst6_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst6_occ", {62'd0, occupancy}, 64'd0);
    check("rst6_bubble", {48'd0, bubble_count}, 64'd0);
    ctrl_reset_n = 1'b1;
    drive(1'b0, '0);
    tick();
    check("rst6_bubble_after", {48'd0, bubble_count}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
